// File: rtl/decoder_scan_nx2n_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
//   state_e      : FSM states (idle / direct decode / autonomous scan)
//   MODE_*       : encoding of the mode input
//   onehot()     : binary select to one-hot, sized for the widest supported N
package decoder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the helper covers; callers zero-extend and keep the low 2^N bits.
  localparam int unsigned MaxN   = 8;
  localparam int unsigned MaxOut = 1 << MaxN;

  function automatic logic [MaxOut-1:0] onehot(input logic [MaxN-1:0] sel);
    logic [MaxOut-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_nx2n_if.sv
// Select/handshake bundle for decoder_scan_nx2n.
//   master : drives en, mode, w, w_valid; observes w_ready, y, y_valid, idx, wrap
//   slave  : the decoder side
interface decoder_scan_nx2n_if #(
  parameter int unsigned N = 2
);
  logic                 en;
  logic                 mode;
  logic [N-1:0]         w;
  logic                 w_valid;
  logic                 w_ready;
  logic [(1 << N)-1:0]  y;
  logic                 y_valid;
  logic [N-1:0]         idx;
  logic                 wrap;

  modport master (
    output en, mode, w, w_valid,
    input  w_ready, y, y_valid, idx, wrap
  );

  modport slave (
    input  en, mode, w, w_valid,
    output w_ready, y, y_valid, idx, wrap
  );
endinterface

// File: rtl/decoder_scan_nx2n_dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while run is high and
// pulses tick during the last dwell cycle, then wraps to 0.
//   clk, rst_n : clock, async active-low reset
//   clr        : hold the count at 0 (has priority over run)
//   run        : advance the count this cycle
//   tick       : high on the final cycle of each dwell period
module dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = run & ~clr & (cnt_q == Last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan_nx2n.sv
// Registered binary-to-one-hot decoder with an autonomous scan mode.
//   clk, rst_n : clock, async active-low reset
//   bus        : decoder_scan_nx2n_if slave
//     en/mode  : 0x idle, 10 direct decode of w, 11 scan all 2^N outputs
//     w/w_valid/w_ready : select handshake (ready only in direct mode)
//     y/y_valid/idx     : registered one-hot output and its binary index
//     wrap              : one-cycle pulse when scan returns from 2^N-1 to 0
// N must not exceed decoder_pkg::MaxN.
module decoder_scan_nx2n
  import decoder_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 4
) (
  input logic                clk,
  input logic                rst_n,
  decoder_scan_nx2n_if.slave bus
);

  localparam int unsigned OutW = 1 << N;

  state_e            state_q;
  logic [OutW-1:0]   y_q;
  logic              y_valid_q;
  logic [N-1:0]      idx_q;
  logic              wrap_q;

  logic              w_ready;
  logic              accept;
  logic              scan_req;
  logic              tick;
  logic [N-1:0]      idx_inc;
  logic [MaxN-1:0]   w_ext;
  logic [MaxN-1:0]   inc_ext;
  logic [MaxOut-1:0] dec_w;
  logic [MaxOut-1:0] dec_inc;
  logic              unused_dec;

  // Ready depends only on the live inputs so it rises in the cycle DIRECT is requested.
  assign w_ready  = bus.en & (bus.mode == MODE_DIRECT);
  assign accept   = bus.w_valid & w_ready;
  assign scan_req = bus.en & (bus.mode == MODE_SCAN);
  assign idx_inc  = idx_q + 1'b1;

  always_comb begin
    w_ext            = '0;
    w_ext[N-1:0]     = bus.w;
    inc_ext          = '0;
    inc_ext[N-1:0]   = idx_inc;
  end

  assign dec_w      = onehot(w_ext);
  assign dec_inc    = onehot(inc_ext);
  // Only the low OutW bits of each decode are used.
  assign unused_dec = ^{dec_w, dec_inc};

  // Counter only runs while staying in scan; any other cycle leaves it at 0 so
  // every scan entry starts a fresh dwell.
  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~(scan_req & (state_q == StScan))),
    .run   (scan_req & (state_q == StScan)),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      idx_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!bus.en) begin
        state_q   <= StIdle;
        y_q       <= '0;
        y_valid_q <= 1'b0;
        idx_q     <= '0;
      end else if (bus.mode == MODE_DIRECT) begin
        // Outputs hold (including a leftover scan value) until a w is accepted.
        state_q <= StDirect;
        if (accept) begin
          y_q       <= dec_w[OutW-1:0];
          y_valid_q <= 1'b1;
          idx_q     <= bus.w;
        end
      end else begin
        state_q <= StScan;
        if (state_q != StScan) begin
          y_q       <= OutW'(1);
          y_valid_q <= 1'b1;
          idx_q     <= '0;
        end else if (tick) begin
          y_q    <= dec_inc[OutW-1:0];
          idx_q  <= idx_inc;
          wrap_q <= (idx_q == '1);
        end
      end
    end
  end

  assign bus.w_ready = w_ready;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.idx     = idx_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
module tb_decoder_scan_nx2n;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  decoder_scan_nx2n_if #(.N(2)) ba ();
  decoder_scan_nx2n_if #(.N(3)) bb ();

  decoder_scan_nx2n #(.N(2), .DWELL(3)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ba.slave)
  );

  decoder_scan_nx2n #(.N(3), .DWELL(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] y;
    logic       yv;
    logic [1:0] idx;
    logic       wrap;
  } exp_a_t;

  typedef struct packed {
    logic       en;
    logic       mode;
    logic [1:0] w;
    logic       wv;
    logic       rdy;
    exp_a_t     exp;
  } step_a_t;

  typedef struct packed {
    logic [7:0] y;
    logic       yv;
    logic [2:0] idx;
    logic       wrap;
  } exp_b_t;

  exp_a_t  sb_a[$];
  exp_b_t  sb_b[$];
  step_a_t steps[$];

  function automatic step_a_t mk(logic en, logic mode, logic [1:0] w, logic wv, logic rdy,
                                 logic [3:0] y, logic yv, logic [1:0] idx, logic wrap);
    step_a_t s;
    s.en = en; s.mode = mode; s.w = w; s.wv = wv; s.rdy = rdy;
    s.exp.y = y; s.exp.yv = yv; s.exp.idx = idx; s.exp.wrap = wrap;
    return s;
  endfunction

  // Output must always be zero or one-hot, never X, and y_valid must track a non-zero y.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!$isunknown(ba.y) && $onehot0(ba.y) && ((ba.y != 4'b0) == ba.y_valid))
      else begin
        errors++;
        $display("FAIL onehot_a: y=%b y_valid=%b", ba.y, ba.y_valid);
      end
      checks++;
      assert (!$isunknown(bb.y) && $onehot0(bb.y) && ((bb.y != 8'b0) == bb.y_valid))
      else begin
        errors++;
        $display("FAIL onehot_b: y=%b y_valid=%b", bb.y, bb.y_valid);
      end
    end
  end

  task automatic test_reset();
    exp_a_t e, got;
    checks++;
    if ({ba.y, ba.y_valid, ba.idx, ba.wrap, ba.w_ready} !== 9'b0) begin
      errors++;
      $display("FAIL reset_a: got y=%b v=%b idx=%0d wrap=%b rdy=%b want all 0",
               ba.y, ba.y_valid, ba.idx, ba.wrap, ba.w_ready);
    end
    checks++;
    if ({bb.y, bb.y_valid, bb.idx, bb.wrap, bb.w_ready} !== 14'b0) begin
      errors++;
      $display("FAIL reset_b: got y=%b v=%b idx=%0d wrap=%b want all 0",
               bb.y, bb.y_valid, bb.idx, bb.wrap);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    steps = {};
    for (int i = 0; i < 3; i++) steps.push_back(mk(0, 0, 2'd3, 1, 0, 4'b0000, 0, 0, 0));
    foreach (steps[i]) begin
      {ba.en, ba.mode, ba.w, ba.w_valid} = {steps[i].en, steps[i].mode, steps[i].w, steps[i].wv};
      sb_a.push_back(steps[i].exp);
      #1;
      checks++;
      if (ba.w_ready !== steps[i].rdy) begin
        errors++;
        $display("FAIL reset.w_ready[%0d]: got %b want %b", i, ba.w_ready, steps[i].rdy);
      end
      @(posedge clk); #1;
      e = sb_a.pop_front();
      got = {ba.y, ba.y_valid, ba.idx, ba.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset.out[%0d]: got y=%b v=%b idx=%0d wrap=%b want y=%b v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_direct();
    exp_a_t e, got;
    steps = {};
    steps.push_back(mk(1, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 0)); // entering DIRECT, nothing accepted
    steps.push_back(mk(1, 0, 2'd2, 1, 1, 4'b0100, 1, 2, 0));
    steps.push_back(mk(1, 0, 2'd1, 0, 1, 4'b0100, 1, 2, 0));
    steps.push_back(mk(1, 0, 2'd3, 0, 1, 4'b0100, 1, 2, 0));
    steps.push_back(mk(1, 0, 2'd0, 1, 1, 4'b0001, 1, 0, 0));
    steps.push_back(mk(1, 0, 2'd3, 1, 1, 4'b1000, 1, 3, 0));
    foreach (steps[i]) begin
      {ba.en, ba.mode, ba.w, ba.w_valid} = {steps[i].en, steps[i].mode, steps[i].w, steps[i].wv};
      sb_a.push_back(steps[i].exp);
      #1;
      checks++;
      if (ba.w_ready !== steps[i].rdy) begin
        errors++;
        $display("FAIL direct.w_ready[%0d]: got %b want %b", i, ba.w_ready, steps[i].rdy);
      end
      @(posedge clk); #1;
      e = sb_a.pop_front();
      got = {ba.y, ba.y_valid, ba.idx, ba.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL direct.out[%0d]: got y=%b v=%b idx=%0d wrap=%b want y=%b v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_scan_sequence();
    exp_a_t e, got;
    int pos;
    steps = {};
    // Two full periods: each position held 3 cycles, wrap on return to bit 0.
    for (int i = 0; i < 26; i++) begin
      pos = (i / 3) % 4;
      steps.push_back(mk(1, 1, 2'd3, 1, 0, 4'b0001 << pos, 1, 2'(pos),
                         (i == 12) || (i == 24)));
    end
    foreach (steps[i]) begin
      {ba.en, ba.mode, ba.w, ba.w_valid} = {steps[i].en, steps[i].mode, steps[i].w, steps[i].wv};
      sb_a.push_back(steps[i].exp);
      #1;
      checks++;
      if (ba.w_ready !== steps[i].rdy) begin
        errors++;
        $display("FAIL scan.w_ready[%0d]: got %b want %b", i, ba.w_ready, steps[i].rdy);
      end
      @(posedge clk); #1;
      e = sb_a.pop_front();
      got = {ba.y, ba.y_valid, ba.idx, ba.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scan.out[%0d]: got y=%b v=%b idx=%0d wrap=%b want y=%b v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_mode_switch();
    exp_a_t e, got;
    steps = {};
    steps.push_back(mk(0, 1, 2'd0, 0, 0, 4'b0000, 0, 0, 0));
    for (int i = 0; i < 7; i++)
      steps.push_back(mk(1, 1, 2'd0, 0, 0, 4'b0001 << (i / 3), 1, 2'(i / 3), 0));
    steps.push_back(mk(1, 0, 2'd1, 0, 1, 4'b0100, 1, 2, 0)); // scan value held
    steps.push_back(mk(1, 0, 2'd1, 0, 1, 4'b0100, 1, 2, 0));
    steps.push_back(mk(1, 0, 2'd3, 1, 1, 4'b1000, 1, 3, 0));
    steps.push_back(mk(1, 1, 2'd2, 1, 0, 4'b0001, 1, 0, 0)); // mode flips with w_valid high
    steps.push_back(mk(1, 1, 2'd0, 0, 0, 4'b0001, 1, 0, 0));
    steps.push_back(mk(1, 1, 2'd0, 0, 0, 4'b0001, 1, 0, 0));
    steps.push_back(mk(1, 1, 2'd0, 0, 0, 4'b0010, 1, 1, 0));
    foreach (steps[i]) begin
      {ba.en, ba.mode, ba.w, ba.w_valid} = {steps[i].en, steps[i].mode, steps[i].w, steps[i].wv};
      sb_a.push_back(steps[i].exp);
      #1;
      checks++;
      if (ba.w_ready !== steps[i].rdy) begin
        errors++;
        $display("FAIL mode_switch.w_ready[%0d]: got %b want %b", i, ba.w_ready, steps[i].rdy);
      end
      @(posedge clk); #1;
      e = sb_a.pop_front();
      got = {ba.y, ba.y_valid, ba.idx, ba.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mode_switch.out[%0d]: got y=%b v=%b idx=%0d wrap=%b want y=%b v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_disable_race();
    exp_a_t e, got;
    steps = {};
    steps.push_back(mk(1, 0, 2'd0, 1, 1, 4'b0001, 1, 0, 0));
    steps.push_back(mk(0, 0, 2'd1, 1, 0, 4'b0000, 0, 0, 0)); // en drop beats w_valid
    steps.push_back(mk(1, 0, 2'd1, 0, 1, 4'b0000, 0, 0, 0)); // dropped w not replayed
    steps.push_back(mk(1, 0, 2'd1, 1, 1, 4'b0010, 1, 1, 0));
    foreach (steps[i]) begin
      {ba.en, ba.mode, ba.w, ba.w_valid} = {steps[i].en, steps[i].mode, steps[i].w, steps[i].wv};
      sb_a.push_back(steps[i].exp);
      #1;
      checks++;
      if (ba.w_ready !== steps[i].rdy) begin
        errors++;
        $display("FAIL disable_race.w_ready[%0d]: got %b want %b", i, ba.w_ready, steps[i].rdy);
      end
      @(posedge clk); #1;
      e = sb_a.pop_front();
      got = {ba.y, ba.y_valid, ba.idx, ba.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL disable_race.out[%0d]: got y=%b v=%b idx=%0d wrap=%b want y=%b v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_reset_midscan();
    exp_a_t e, got;
    steps = {};
    for (int i = 0; i < 5; i++)
      steps.push_back(mk(1, 1, 2'd0, 0, 0, 4'b0001 << (i / 3), 1, 2'(i / 3), 0));
    foreach (steps[i]) begin
      {ba.en, ba.mode, ba.w, ba.w_valid} = {steps[i].en, steps[i].mode, steps[i].w, steps[i].wv};
      sb_a.push_back(steps[i].exp);
      @(posedge clk); #1;
      e = sb_a.pop_front();
      got = {ba.y, ba.y_valid, ba.idx, ba.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid.pre[%0d]: got y=%b v=%b idx=%0d wrap=%b want y=%b v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
    // Asynchronous: outputs clear between clock edges.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ba.y, ba.y_valid, ba.idx, ba.wrap} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid.async: got y=%b v=%b idx=%0d wrap=%b want all 0",
               ba.y, ba.y_valid, ba.idx, ba.wrap);
    end
    ba.en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    steps = {};
    for (int i = 0; i < 3; i++) steps.push_back(mk(0, 1, 2'd0, 0, 0, 4'b0000, 0, 0, 0));
    steps.push_back(mk(1, 1, 2'd0, 0, 0, 4'b0001, 1, 0, 0));
    foreach (steps[i]) begin
      {ba.en, ba.mode, ba.w, ba.w_valid} = {steps[i].en, steps[i].mode, steps[i].w, steps[i].wv};
      sb_a.push_back(steps[i].exp);
      @(posedge clk); #1;
      e = sb_a.pop_front();
      got = {ba.y, ba.y_valid, ba.idx, ba.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid.post[%0d]: got y=%b v=%b idx=%0d wrap=%b want y=%b v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
    ba.en = 1'b0;
  endtask

  task automatic test_width_sweep();
    exp_b_t e, got;
    for (int i = 0; i < 20; i++) begin
      bb.en = 1'b1; bb.mode = 1'b1; bb.w = 3'd5; bb.w_valid = 1'b1;
      e.y    = 8'b1 << (i % 8);
      e.yv   = 1'b1;
      e.idx  = 3'(i % 8);
      e.wrap = (i > 0) && (i % 8 == 0);
      sb_b.push_back(e);
      #1;
      checks++;
      if (bb.w_ready !== 1'b0) begin
        errors++;
        $display("FAIL sweep.w_ready[%0d]: got %b want 0", i, bb.w_ready);
      end
      @(posedge clk); #1;
      e = sb_b.pop_front();
      got = {bb.y, bb.y_valid, bb.idx, bb.wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL sweep.out[%0d]: got y=%h v=%b idx=%0d wrap=%b want y=%h v=%b idx=%0d wrap=%b",
                 i, got.y, got.yv, got.idx, got.wrap, e.y, e.yv, e.idx, e.wrap);
      end
    end
    bb.en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {ba.en, ba.mode, ba.w, ba.w_valid} = '0;
    {bb.en, bb.mode, bb.w, bb.w_valid} = '0;
    #12;
    test_reset();
    test_direct();
    test_scan_sequence();
    test_mode_switch();
    test_disable_race();
    test_reset_midscan();
    test_width_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
